dac_stream_capture: RTL and testbench

//  Receive-side monitor for the feed-forward amplifier DAC bus. Sits on the

---
 rtl/dac_stream_capture_if.sv | 22 ++
 rtl/dac_stream_capture.sv | 151 +++++++++++++++
 tb/tb_dac_stream_capture.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_stream_capture_if.sv
// DAC sample bus plus buffer read port of the capture monitor.
// The master drives the DAC pins and issues reads; the capture block is the slave.
interface dac_stream_capture_if #(
   parameter int ADDR_W = 8
) ();
   logic                dac_en;
   logic signed [12:0]  dac_din;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic signed [12:0]  rd_data;
   logic                rd_valid;

   modport master (
      output dac_en, dac_din, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  dac_en, dac_din, rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/dac_stream_capture.sv
// Receive-side monitor for the amplifier DAC bus: recovers one sample per
// rising edge of dac_en, stores a burst in on-chip RAM and tracks count,
// overflow and signed peaks. The buffer is read back through a registered port.
module dac_stream_capture #(
   parameter int ADDR_W      = 8,
   parameter int GAP_TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm,
   dac_stream_capture_if.slave  bus,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W:0]      n_samples,
   output logic                 ovf,
   output logic signed [12:0]   peak_max,
   output logic signed [12:0]   peak_min
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(GAP_TIMEOUT);
   localparam logic [ADDR_W:0]   LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
   localparam logic signed [12:0] MAX_INIT = -13'sd4096;
   localparam logic signed [12:0] MIN_INIT = 13'sd4095;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                en_q, en_qq;
   logic signed [12:0]  din_q;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [ADDR_W:0]     n_q, n_d;
   logic                ovf_q, ovf_d;
   logic signed [12:0]  max_q, max_d, min_q, min_d;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic signed [12:0]  rd_data_q;
   logic                rd_valid_q;
   logic                edge_det, full, last_slot, gap_hit;

   logic signed [12:0]  mem [DEPTH];

   assign edge_det  = en_q & ~en_qq;
   assign full      = n_q[ADDR_W];
   assign last_slot = (n_q == LAST_IDX);
   assign gap_hit   = !en_q && (gap_q + 1'b1 == GAP_LIM);

   // Pin input stage: one register on the DAC pins, one more for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q  <= 1'b0;
         en_qq <= 1'b0;
         din_q <= '0;
      end else begin
         en_q  <= bus.dac_en;
         en_qq <= en_q;
         din_q <= bus.dac_din;
      end
   end

   // State and burst-status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         n_q     <= '0;
         ovf_q   <= 1'b0;
         max_q   <= MAX_INIT;
         min_q   <= MIN_INIT;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         n_q     <= n_d;
         ovf_q   <= ovf_d;
         max_q   <= max_d;
         min_q   <= min_d;
      end
   end

   // Next-state logic; arm only has effect from IDLE or DONE, where it also beats a coincident edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (arm) state_d = S_ARMED;
         S_ARMED:   if (edge_det) state_d = S_CAPTURE;
         S_CAPTURE: if ((edge_det && last_slot) || gap_hit) state_d = S_DONE;
         S_DONE:    if (arm) state_d = S_ARMED;
         default:   state_d = S_IDLE;
      endcase
   end

   // Burst datapath: sample writes, count, gap timer, overflow and signed peaks.
   always_comb begin
      gap_d   = gap_q;
      n_d     = n_q;
      ovf_d   = ovf_q;
      max_d   = max_q;
      min_d   = min_q;
      wr_en   = 1'b0;
      wr_addr = n_q[ADDR_W-1:0];
      if ((state_q == S_IDLE || state_q == S_DONE) && arm) begin
         gap_d = '0;
         n_d   = '0;
         ovf_d = 1'b0;
         max_d = MAX_INIT;
         min_d = MIN_INIT;
      end else if ((state_q == S_ARMED || state_q == S_CAPTURE) && edge_det && !full) begin
         // An edge implies en_q=1, so the gap timer restarts here as well.
         gap_d = '0;
         wr_en = 1'b1;
         n_d   = n_q + 1'b1;
         if (din_q > max_q) max_d = din_q;
         if (din_q < min_q) min_d = din_q;
      end else if (state_q == S_CAPTURE) begin
         gap_d = en_q ? '0 : gap_q + 1'b1;
      end else if (state_q == S_DONE && edge_det && full) begin
         ovf_d = 1'b1;
      end
   end

   // Output decode from the current state.
   always_comb begin
      busy = (state_q == S_ARMED) || (state_q == S_CAPTURE);
      done = (state_q == S_DONE);
   end

   // Sample buffer write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= din_q;
   end

   // Registered read port; rd_data holds its last value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign n_samples    = n_q;
   assign ovf          = ovf_q;
   assign peak_max     = max_q;
   assign peak_min     = min_q;

endmodule

// File: tb/tb_dac_stream_capture.sv
// Directed bench for dac_stream_capture: a full-size instance and a 16-deep
// instance share clock and reset; all stimulus changes on the falling edge.
module tb_dac_stream_capture;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic b_arm = 1'b0, s_arm = 1'b0;
   logic b_busy, b_done, b_ovf, s_busy, s_done, s_ovf;
   logic [8:0] b_n;
   logic [4:0] s_n;
   logic signed [12:0] b_pmax, b_pmin, s_pmax, s_pmin;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dac_stream_capture_if #(.ADDR_W(8)) b_if ();
   dac_stream_capture_if #(.ADDR_W(4)) s_if ();

   dac_stream_capture #(.ADDR_W(8), .GAP_TIMEOUT(8)) u_big (
      .clk(clk), .rst_n(rst_n), .arm(b_arm), .bus(b_if.slave),
      .busy(b_busy), .done(b_done), .n_samples(b_n), .ovf(b_ovf),
      .peak_max(b_pmax), .peak_min(b_pmin)
   );

   dac_stream_capture #(.ADDR_W(4), .GAP_TIMEOUT(8)) u_small (
      .clk(clk), .rst_n(rst_n), .arm(s_arm), .bus(s_if.slave),
      .busy(s_busy), .done(s_done), .n_samples(s_n), .ovf(s_ovf),
      .peak_max(s_pmax), .peak_min(s_pmin)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // All tasks are entered and left on a falling edge.
   task automatic do_arm(input bit sel);
      if (sel) s_arm = 1'b1; else b_arm = 1'b1;
      @(negedge clk);
      s_arm = 1'b0;
      b_arm = 1'b0;
   endtask

   // One 2-cycle DAC_en period; on return the sample has been written.
   task automatic pulse(input bit sel, input int v);
      if (sel) begin s_if.dac_en = 1'b1; s_if.dac_din = 13'(v); end
      else     begin b_if.dac_en = 1'b1; b_if.dac_din = 13'(v); end
      @(negedge clk);
      s_if.dac_en = 1'b0;
      b_if.dac_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic rd_chk(input bit sel, input int addr, input int exp);
      if (sel) begin s_if.rd_en = 1'b1; s_if.rd_addr = 4'(addr); end
      else     begin b_if.rd_en = 1'b1; b_if.rd_addr = 8'(addr); end
      @(negedge clk);
      s_if.rd_en = 1'b0;
      b_if.rd_en = 1'b0;
      chk($sformatf("rd_valid[%0d]", addr), sel ? int'(s_if.rd_valid) : int'(b_if.rd_valid), 1);
      chk($sformatf("rd_data[%0d]", addr), sel ? int'(s_if.rd_data) : int'(b_if.rd_data), exp);
   endtask

   initial begin
      b_if.dac_en = 1'b0; b_if.dac_din = '0; b_if.rd_en = 1'b0; b_if.rd_addr = '0;
      s_if.dac_en = 1'b0; s_if.dac_din = '0; s_if.rd_en = 1'b0; s_if.rd_addr = '0;

      // Reset values
      idle(3);
      chk("rst_busy", int'(b_busy), 0);
      chk("rst_done", int'(b_done), 0);
      chk("rst_n_samples", int'(b_n), 0);
      chk("rst_ovf", int'(b_ovf), 0);
      chk("rst_peak_max", int'(b_pmax), -4096);
      chk("rst_peak_min", int'(b_pmin), 4095);
      chk("rst_rd_valid", int'(b_if.rd_valid), 0);
      chk("rst_rd_data", int'(b_if.rd_data), 0);
      rst_n = 1'b1;
      idle(2);

      // 1: ten samples 1..10, burst ends on the gap timeout
      do_arm(0);
      chk("t1_busy_armed", int'(b_busy), 1);
      for (int i = 1; i <= 10; i++) pulse(0, i);
      idle(5);
      chk("t1_done_early", int'(b_done), 0);
      chk("t1_busy_in_gap", int'(b_busy), 1);
      idle(15);
      chk("t1_done", int'(b_done), 1);
      chk("t1_n_samples", int'(b_n), 10);
      chk("t1_peak_max", int'(b_pmax), 10);
      chk("t1_peak_min", int'(b_pmin), 1);
      for (int i = 0; i < 10; i++) rd_chk(0, i, i + 1);
      @(negedge clk);
      chk("t1_rd_valid_low", int'(b_if.rd_valid), 0);

      // 2: five samples then a short gap and a clear pulse of value 0
      do_arm(0);
      chk("t2_n_cleared", int'(b_n), 0);
      for (int i = 11; i <= 15; i++) pulse(0, i);
      idle(3);
      pulse(0, 0);
      idle(20);
      chk("t2_done", int'(b_done), 1);
      chk("t2_n_samples", int'(b_n), 6);
      chk("t2_peak_min", int'(b_pmin), 0);
      chk("t2_peak_max", int'(b_pmax), 15);
      rd_chk(0, 4, 15);
      rd_chk(0, 5, 0);

      // 3: 16-deep buffer, 20 edges: full at the 16th, overflow at the 17th
      do_arm(1);
      for (int i = 0; i < 20; i++) begin
         pulse(1, 100 + i);
         if (i == 14) chk("t3_busy_15", int'(s_busy), 1);
         if (i == 15) begin
            chk("t3_done_16", int'(s_done), 1);
            chk("t3_n_16", int'(s_n), 16);
            chk("t3_ovf_16", int'(s_ovf), 0);
         end
         if (i == 16) chk("t3_ovf_17", int'(s_ovf), 1);
      end
      chk("t3_n_final", int'(s_n), 16);
      chk("t3_ovf_final", int'(s_ovf), 1);
      rd_chk(1, 0, 100);
      rd_chk(1, 15, 115);

      // 4: signed extremes
      do_arm(0);
      pulse(0, -4096);
      pulse(0, 4095);
      pulse(0, -1);
      idle(20);
      chk("t4_n_samples", int'(b_n), 3);
      chk("t4_peak_max", int'(b_pmax), 4095);
      chk("t4_peak_min", int'(b_pmin), -4096);
      rd_chk(0, 0, -4096);
      rd_chk(0, 1, 4095);
      rd_chk(0, 2, -1);

      // 5: asynchronous reset at the third sample of a burst
      do_arm(0);
      pulse(0, 31);
      pulse(0, 32);
      b_if.dac_en = 1'b1; b_if.dac_din = 13'd33;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", int'(b_busy), 0);
      chk("t5_n_samples", int'(b_n), 0);
      chk("t5_peak_max", int'(b_pmax), -4096);
      chk("t5_rd_data", int'(b_if.rd_data), 0);
      @(negedge clk);
      b_if.dac_en = 1'b0;
      rst_n = 1'b1;
      idle(2);
      chk("t5_idle_done", int'(b_done), 0);
      do_arm(0);
      pulse(0, 41);
      pulse(0, 42);
      idle(20);
      chk("t5_n_after", int'(b_n), 2);
      chk("t5_done_after", int'(b_done), 1);
      rd_chk(0, 1, 42);

      // 6: arm during CAPTURE ignored; arm beats a coincident edge in DONE
      do_arm(0);
      pulse(0, 61);
      pulse(0, 62);
      do_arm(0);
      chk("t6_n_arm_ignored", int'(b_n), 2);
      pulse(0, 63);
      pulse(0, 64);
      idle(20);
      chk("t6_n_samples", int'(b_n), 4);
      rd_chk(0, 3, 64);
      b_if.dac_en = 1'b1; b_if.dac_din = 13'd77;
      @(negedge clk);
      b_if.dac_en = 1'b0;
      b_arm = 1'b1;
      @(negedge clk);
      b_arm = 1'b0;
      chk("t6_busy_rearm", int'(b_busy), 1);
      chk("t6_done_rearm", int'(b_done), 0);
      chk("t6_n_rearm", int'(b_n), 0);
      pulse(0, 88);
      idle(20);
      chk("t6_n_final", int'(b_n), 1);
      chk("t6_peak_max", int'(b_pmax), 88);
      rd_chk(0, 0, 88);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
